btb_assoc: RTL
==============

Name: btb_assoc

Overview:
- Parametrised N-way set-associative branch target buffer with per-entry 2-bit saturating direction counters. Next-generation replacement for the direct-mapped BTB.
- Lookup is combinational in IF: it returns predicted next PC, hit and predicted-taken for i_pc_IF.
- Training happens one cycle after EX resolution: the EX stage drives the resolved PC, target and outcome.
- Adds associativity, direction prediction, allocate-on-taken-only, replacement policy and a synchronous flush, none of which the direct-mapped BTB had.

Parameters:
- SETS, 256, number of sets; power of 2, ≥2; IDX_W = log2(SETS).
- WAYS, 2, ways per set; one of 1, 2, 4; WAY_W = max(1, log2(WAYS)).
- CNT_W, 2, direction counter width; fixed at 2 in this generation.
- TAG_W, 30-IDX_W, derived, not overridable; index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_pc_IF  in  32  fetch PC to look up.
- i_flush  in  1  synchronous invalidate of all entries.
- i_upd_en  in  1  update strobe from EX; pc/target/taken are valid while high.
- i_upd_pc  in  32  PC of the resolved branch or jump.
- i_upd_target  in  32  resolved target address.
- i_upd_taken  in  1  resolved direction (jumps always 1).
- o_pred_pc_IF  out  32  predicted next PC.
- o_btb_hit  out  1  tag match in some valid way.
- o_pred_taken  out  1  hit and counter MSB = 1.
- o_hit_way  out  WAY_W  way that hit (0 on miss); carried down the pipe for debug.

Behaviour:
- Reset (async, asserts immediately):
  - all valid bits 0, all counters 2'b01 (weakly not-taken), all round-robin pointers 0.
  - Outputs are then o_btb_hit=0, o_pred_taken=0, o_hit_way=0, o_pred_pc_IF = i_pc_IF+4.
- Lookup (combinational, zero latency):
  - hit = any way w in set idx(i_pc_IF) with valid & tag equal.
  - At most one way may match; allocation guarantees this.
  - o_pred_pc_IF = target[w] when hit & counter[w][1], else i_pc_IF+4 (32-bit wrap, carry dropped).
- Update (registered, takes effect at the next edge), when i_upd_en=1 and i_flush=0:
  - Hit in way w:
    - counter saturating ±1 (inc on taken, dec on not-taken; 11 stays 11, 00 stays 00).
    - if taken, target[w] <= i_upd_target.
    - valid and tag unchanged.
  - Miss & taken: allocate.
    - victim = lowest-index invalid way; if none, rr_ptr[set].
    - write valid=1, tag, target, counter=2'b10 (weakly taken).
    - rr_ptr[set] <= rr_ptr+1 (mod WAYS) only when the victim came from rr_ptr.
  - Miss & not-taken: no state change.
- Flush: i_flush=1 clears all valid bits at the edge; counters, targets and pointers are retained. Flush has priority over a same-cycle update, which is dropped.
- Lookup/update to the same set in the same cycle: the lookup sees pre-update contents (read-before-write). No bypass.
- Reset mid-update: the reset wins and the update is lost.
- WAYS=1: degenerates to direct-mapped; rr_ptr is unused and o_hit_way is tied 0.

Decomposition:
- Package btb_pkg holds:
  - counter encodings CNT_SNT=2'b00, CNT_WNT=2'b01, CNT_WT=2'b10, CNT_ST=2'b11.
  - the functions cnt_next(cnt, taken), idx_of(pc) and tag_of(pc).
- Sub-module btb_way, instanced WAYS times. Each instance holds:
  - per-set valid/tag/target/counter arrays.
  - async reset of valid/counter.
  - a combinational read port and a write port with a per-field write mask.
- The top holds way-select logic, victim selection, rr_ptr array and the output mux.

Test Plan (SETS=256, WAYS=2; PCs 0x100, 0x500, 0x900 all map to set 0x40):
- After reset, i_pc_IF=0x100 -> o_btb_hit=0, o_pred_taken=0, o_pred_pc_IF=0x104.
- Allocation on taken branch:
  - Stimulus: upd pc=0x100 target=0x2000 taken=1, then lookup 0x100.
  - Required: hit=1, way 0, pred_taken=1, pred_pc=0x2000.
  - Then upd pc=0x180 taken=0 -> lookup 0x180 misses (no allocation on not-taken).
- Counter training: on 0x100 (counter 10), two not-taken updates.
  - After the first: counter 01, lookup gives hit=1, pred_taken=0, pred_pc=0x104.
  - After the second: counter 00; a further not-taken update keeps it 00.
  - Three taken updates -> counter 11; a fourth stays 11.
- Replacement:
  - Allocate 0x100 (way 0), then 0x500 (way 1); both hit.
  - Allocate 0x900 (target 0x3000) -> evicts way 0 (rr_ptr=0) and rr_ptr becomes 1.
  - Result: 0x100 misses; 0x500 and 0x900 hit.
- Same-cycle lookup/update of 0x100 (new target 0x4000):
  - In the update cycle, o_pred_pc_IF shows the old target 0x2000.
  - In the following cycle it shows 0x4000.
- Flush with a concurrent update of 0x500: no update applied, all lookups miss afterwards. Assert i_rst asynchronously mid-cycle -> outputs return to reset values before the next edge.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer:
// counter encodings, per-field write mask and PC slicing functions.
package btb_pkg;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    typedef struct packed {
        logic valid;
        logic tag;
        logic target;
        logic cnt;
    } wr_mask_t;

    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        else
            return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

    // Word-aligned PCs: bits [1:0] never take part in index or tag.
    function automatic logic [31:0] idx_of(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: per-set valid/tag/target/counter storage with a lookup
// read port, an update read port and a masked write port.
module btb_way
    import btb_pkg::*;
#(
    parameter int SETS  = 256,
    parameter int IDX_W = 8,
    parameter int TAG_W = 22,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IDX_W-1:0] lk_idx,
    output logic             lk_valid,
    output logic [TAG_W-1:0] lk_tag,
    output logic [31:0]      lk_target,
    output logic [CNT_W-1:0] lk_cnt,
    input  logic [IDX_W-1:0] wr_idx,
    output logic             up_valid,
    output logic [TAG_W-1:0] up_tag,
    output logic [CNT_W-1:0] up_cnt,
    input  logic             wr_en,
    input  wr_mask_t         wr_mask,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target,
    input  logic [CNT_W-1:0] wr_cnt
);

    logic             valid_mem  [SETS];
    logic [CNT_W-1:0] cnt_mem    [SETS];
    logic [TAG_W-1:0] tag_mem    [SETS];
    logic [31:0]      target_mem [SETS];

    assign lk_valid  = valid_mem[lk_idx];
    assign lk_tag    = tag_mem[lk_idx];
    assign lk_target = target_mem[lk_idx];
    assign lk_cnt    = cnt_mem[lk_idx];
    assign up_valid  = valid_mem[wr_idx];
    assign up_tag    = tag_mem[wr_idx];
    assign up_cnt    = cnt_mem[wr_idx];

    // Flush only drops valid bits; trained counters survive it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= 1'b0;
                cnt_mem[s]   <= CNT_W'(CNT_WNT);
            end
        end else if (flush) begin
            for (int s = 0; s < SETS; s++)
                valid_mem[s] <= 1'b0;
        end else if (wr_en) begin
            if (wr_mask.valid) valid_mem[wr_idx] <= 1'b1;
            if (wr_mask.cnt)   cnt_mem[wr_idx]   <= wr_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            if (wr_mask.tag)    tag_mem[wr_idx]    <= wr_tag;
            if (wr_mask.target) target_mem[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative BTB with 2-bit direction counters: combinational
// lookup, registered training, allocate-on-taken with round-robin eviction.
module btb_assoc
    import btb_pkg::*;
#(
    parameter  int SETS  = 256,
    parameter  int WAYS  = 2,
    parameter  int CNT_W = 2,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_pc_IF,
    input  logic             i_flush,
    input  logic             i_upd_en,
    input  logic [31:0]      i_upd_pc,
    input  logic [31:0]      i_upd_target,
    input  logic             i_upd_taken,
    output logic [31:0]      o_pred_pc_IF,
    output logic             o_btb_hit,
    output logic             o_pred_taken,
    output logic [WAY_W-1:0] o_hit_way
);

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;

    assign lk_idx = IDX_W'(idx_of(i_pc_IF, IDX_W));
    assign lk_tag = TAG_W'(tag_of(i_pc_IF, IDX_W));
    assign up_idx = IDX_W'(idx_of(i_upd_pc, IDX_W));
    assign up_tag = TAG_W'(tag_of(i_upd_pc, IDX_W));

    logic [WAYS-1:0]  lk_valid, lk_hit, up_valid, up_hit;
    logic [TAG_W-1:0] lk_tag_w    [WAYS];
    logic [TAG_W-1:0] up_tag_w    [WAYS];
    logic [31:0]      lk_target_w [WAYS];
    logic [CNT_W-1:0] lk_cnt_w    [WAYS];
    logic [CNT_W-1:0] up_cnt_w    [WAYS];

    logic             upd_go, up_any_hit, alloc, victim_from_rr;
    logic [WAY_W-1:0] victim, rr_next;
    logic [WAY_W-1:0] rr_ptr [SETS];

    assign upd_go     = i_upd_en && !i_flush;
    assign up_any_hit = |up_hit;
    assign alloc      = upd_go && !up_any_hit && i_upd_taken;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            logic             wr_en_g;
            wr_mask_t         wr_mask_g;
            logic [CNT_W-1:0] wr_cnt_g;

            assign lk_hit[gi] = lk_valid[gi] && (lk_tag_w[gi] == lk_tag);
            assign up_hit[gi] = up_valid[gi] && (up_tag_w[gi] == up_tag);

            // A hit only trains; the target moves only on a taken outcome.
            always_comb begin
                wr_en_g   = 1'b0;
                wr_mask_g = '0;
                wr_cnt_g  = up_cnt_w[gi];
                if (upd_go && up_hit[gi]) begin
                    wr_en_g          = 1'b1;
                    wr_mask_g.cnt    = 1'b1;
                    wr_mask_g.target = i_upd_taken;
                    wr_cnt_g         = cnt_next(up_cnt_w[gi], i_upd_taken);
                end else if (alloc && victim == WAY_W'(gi)) begin
                    wr_en_g   = 1'b1;
                    wr_mask_g = '1;
                    wr_cnt_g  = CNT_WT;
                end
            end

            btb_way #(
                .SETS (SETS),
                .IDX_W(IDX_W),
                .TAG_W(TAG_W),
                .CNT_W(CNT_W)
            ) u_way (
                .clk      (i_clk),
                .rst      (i_rst),
                .flush    (i_flush),
                .lk_idx   (lk_idx),
                .lk_valid (lk_valid[gi]),
                .lk_tag   (lk_tag_w[gi]),
                .lk_target(lk_target_w[gi]),
                .lk_cnt   (lk_cnt_w[gi]),
                .wr_idx   (up_idx),
                .up_valid (up_valid[gi]),
                .up_tag   (up_tag_w[gi]),
                .up_cnt   (up_cnt_w[gi]),
                .wr_en    (wr_en_g),
                .wr_mask  (wr_mask_g),
                .wr_tag   (up_tag),
                .wr_target(i_upd_target),
                .wr_cnt   (wr_cnt_g)
            );
        end
    endgenerate

    // Prefer the lowest invalid way; fall back to the set's round-robin pointer.
    always_comb begin
        victim         = rr_ptr[up_idx];
        victim_from_rr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!up_valid[w]) begin
                victim         = WAY_W'(w);
                victim_from_rr = 1'b0;
            end
        end
    end

    assign rr_next = (rr_ptr[up_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[up_idx] + WAY_W'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < SETS; s++)
                rr_ptr[s] <= '0;
        end else if (alloc && victim_from_rr) begin
            rr_ptr[up_idx] <= rr_next;
        end
    end

    logic [31:0]      sel_target;
    logic [CNT_W-1:0] sel_cnt;

    always_comb begin
        o_hit_way  = '0;
        sel_target = '0;
        sel_cnt    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (lk_hit[w]) begin
                o_hit_way  = WAY_W'(w);
                sel_target = lk_target_w[w];
                sel_cnt    = lk_cnt_w[w];
            end
        end
    end

    assign o_btb_hit    = |lk_hit;
    assign o_pred_taken = o_btb_hit && sel_cnt[CNT_W-1];
    assign o_pred_pc_IF = o_pred_taken ? sel_target : i_pc_IF + 32'd4;

endmodule
